// File: rtl/jtkiwi_vtgen.sv
// jtkiwi_vtgen -- parametrised video timing generator.
//
// Produces the pixel/line counters and the blanking/sync flags used by the
// gfx and colmix blocks. The geometry comes from parameters. H/V sync can be
// nudged at run time by small signed offsets, which are sampled only at the
// frame boundary so that a frame never sees a half-applied shift.
//
// Ports
//   clk, rst            system clock, asynchronous active-high reset
//   pxl_cen             pixel clock enable; nothing moves while it is low
//   hoffset, voffset    signed HS (pixels) / VS (lines) shifts, -8..+7
//   hdump, vdump        current pixel / line
//   vrender             vdump + RLEAD wrapped into the vdump range
//   LHBL, LVBL          low during horizontal / vertical blank
//   HS, VS              active-high syncs; VS edges coincide with HS rises
//   Hinit, Vinit        last pixel of the line / of the frame
//   frame_cnt           completed-frame count, wraps
module jtkiwi_vtgen #(
   parameter int W        = 9,
   parameter int H_TOTAL  = 384,
   parameter int HB_START = 256,
   parameter int HB_END   = 0,
   parameter int HS_START = 296,
   parameter int HS_LEN   = 32,
   parameter int V_START  = 16,
   parameter int V_TOTAL  = 264,
   parameter int VB_START = 240,
   parameter int VB_END   = 16,
   parameter int VS_START = 255,
   parameter int VS_LEN   = 3,
   parameter int RLEAD    = 1,
   parameter int FCNT_W   = 8
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              pxl_cen,
   input  logic signed [3:0] hoffset,
   input  logic signed [3:0] voffset,
   output logic [W-1:0]      hdump,
   output logic [W-1:0]      vdump,
   output logic [W-1:0]      vrender,
   output logic              LHBL,
   output logic              LVBL,
   output logic              HS,
   output logic              VS,
   output logic              Hinit,
   output logic              Vinit,
   output logic [FCNT_W-1:0] frame_cnt
);

   // Two guard bits so sums/differences of positions and offsets never overflow.
   localparam int XW = W + 2;
   typedef logic signed [XW-1:0] sx_t;

   localparam logic [W-1:0] H_LAST  = W'(H_TOTAL - 1);
   localparam logic [W-1:0] V_FIRST = W'(V_START);
   localparam logic [W-1:0] V_LAST  = W'(V_START + V_TOTAL - 1);
   localparam logic [W-1:0] RL_W    = W'(RLEAD);
   localparam logic [W-1:0] VT_W    = W'(V_TOTAL);

   localparam sx_t ZERO_X  = sx_t'(0);
   localparam sx_t ONE_X   = sx_t'(1);
   localparam sx_t HT_X    = sx_t'(H_TOTAL);
   localparam sx_t HBS_X   = sx_t'(HB_START);
   localparam sx_t HBE_X   = sx_t'(HB_END);
   localparam sx_t HSS_X   = sx_t'(HS_START);
   localparam sx_t HSL_X   = sx_t'(HS_LEN);
   localparam sx_t VST_X   = sx_t'(V_START);
   localparam sx_t VT_X    = sx_t'(V_TOTAL);
   localparam sx_t VLAST_X = sx_t'(V_START + V_TOTAL - 1);
   localparam sx_t VBS_X   = sx_t'(VB_START);
   localparam sx_t VBE_X   = sx_t'(VB_END);
   localparam sx_t VSS_X   = sx_t'(VS_START);
   localparam sx_t VSL_X   = sx_t'(VS_LEN);
   localparam sx_t RL_X    = sx_t'(RLEAD);

   localparam int           VR_SUM = V_START + RLEAD;
   localparam logic [W-1:0] VR_RST = W'((VR_SUM > V_START + V_TOTAL - 1) ?
                                        VR_SUM - V_TOTAL : VR_SUM);

   // Bring x back into [lo, lo+span); x is never more than one span away.
   function automatic sx_t wrap_span(input sx_t x, input sx_t lo, input sx_t span);
      sx_t r;
      r = x;
      if (r < lo)             r = r + span;
      else if (r >= lo + span) r = r - span;
      return r;
   endfunction

   // Membership of the half-open window [s, e), which wraps when e < s.
   function automatic logic in_window(input sx_t x, input sx_t s, input sx_t e);
      if (s <= e) return (x >= s) && (x < e);
      else        return (x >= s) || (x < e);
   endfunction

   function automatic sx_t sext4(input logic signed [3:0] o);
      return {{(XW-4){o[3]}}, o};
   endfunction

   sx_t          hoff_l, voff_l, hoff_nxt, voff_nxt;
   sx_t          h_x, v_x, hs_s, vs_s, hd, vd;
   logic [W-1:0] h_nxt, v_nxt, vr_nxt;
   logic         lhbl_nxt, lvbl_nxt, hs_nxt, vs_nxt, hinit_nxt, vinit_nxt;

   // Next-state counters and the flags that describe them, so every flag
   // lands in the same cycle as the position it belongs to.
   always_comb begin
      h_nxt = (hdump == H_LAST) ? '0 : hdump + W'(1);
      v_nxt = vdump;
      if (hdump == H_LAST)
         v_nxt = (vdump == V_LAST) ? V_FIRST : vdump + W'(1);

      // Offsets switch on the edge leaving the last frame pixel; that edge
      // already computes the first pixel of the new frame, so it must see them.
      hoff_nxt = Vinit ? sext4(hoffset) : hoff_l;
      voff_nxt = Vinit ? sext4(voffset) : voff_l;

      h_x  = {2'b00, h_nxt};
      v_x  = {2'b00, v_nxt};
      hs_s = wrap_span(HSS_X + hoff_nxt, ZERO_X, HT_X);
      vs_s = wrap_span(VSS_X + voff_nxt, VST_X, VT_X);

      // Distance past the effective sync start, modulo the line / frame.
      hd = h_x - hs_s;
      if (hd[XW-1]) hd = hd + HT_X;
      vd = v_x - vs_s;
      if (vd[XW-1]) vd = vd + VT_X;

      hs_nxt = hd < HSL_X;
      // VS spans from (vs_s, hs_s) up to but excluding (vs_s+VS_LEN, hs_s).
      vs_nxt = ((vd < VSL_X) && (h_x >= hs_s)) ||
               ((vd >= ONE_X) && (vd <= VSL_X) && (h_x < hs_s));

      vr_nxt = v_nxt + RL_W;
      if (v_x + RL_X > VLAST_X) vr_nxt = vr_nxt - VT_W;

      lhbl_nxt  = !in_window(h_x, HBS_X, HBE_X);
      lvbl_nxt  = !in_window(v_x, VBS_X, VBE_X);
      hinit_nxt = (h_nxt == H_LAST);
      vinit_nxt = hinit_nxt && (v_nxt == V_LAST);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hdump     <= '0;
         vdump     <= V_FIRST;
         vrender   <= VR_RST;
         LHBL      <= 1'b0;
         LVBL      <= 1'b0;
         HS        <= 1'b0;
         VS        <= 1'b0;
         Hinit     <= 1'b0;
         Vinit     <= 1'b0;
         frame_cnt <= '0;
         hoff_l    <= '0;
         voff_l    <= '0;
      end else if (pxl_cen) begin
         hdump   <= h_nxt;
         vdump   <= v_nxt;
         vrender <= vr_nxt;
         LHBL    <= lhbl_nxt;
         LVBL    <= lvbl_nxt;
         HS      <= hs_nxt;
         VS      <= vs_nxt;
         Hinit   <= hinit_nxt;
         Vinit   <= vinit_nxt;
         hoff_l  <= hoff_nxt;
         voff_l  <= voff_nxt;
         if (Vinit) frame_cnt <= frame_cnt + FCNT_W'(1);
      end
   end

endmodule
